dac_update_scheduler: RTL and testbench
=======================================

// Module: dac_update_scheduler
// PURPOSE
//  Owns the serial DAC-programming link of the chip (chip_clk/chip_rst/chip_data_in). Holds an 8-entry
//  DAC level table written by the host, tracks which channels changed, and schedules their serial frames
//  round-robin on a divided chip clock. The first sequence after reset or a cfg_init request
//  starts with the chip-reset preamble.
// PARAMETERS
//  CLK_DIV   4000  clk cycles per chip_clk period / per serial slot (even, >=4); HALF = CLK_DIV/2
// PORTS
//  clk          in   1  system clock
//  rst          in   1  reset, asynchronous, active-low
//  en           in   1  scheduler enable; level-sensitive
//  cfg_we       in   1  table write strobe, one entry per cycle, always accepted
//  cfg_addr     in   3  DAC channel to write
//  cfg_level    in   8  DAC level value
//  cfg_init     in   1  1-cycle pulse: request the preamble before the next frame
//  chip_clk     out  1  serial clock to chip
//  chip_rst     out  1  chip reset, active-low
//  chip_data_in out  1  serial data to chip
//  busy         out  1  sequence in progress
//  done         out  1  1-cycle pulse on return to IDLE
//  cur_ch       out  3  channel of frame in flight (last one sent when idle)
//  dirty        out  8  per-channel pending-update flags
// BEHAVIOUR
//  Reset (async): table=0, dirty=0, init flag=1, rr pointer=0, cur_ch=0, busy=0, done=0, chip_clk=0,
//   chip_rst=0 (chip stays held in reset until preamble slot P2), chip_data_in=0, divider=0.
//  cfg_we: table[cfg_addr]<=cfg_level, dirty[cfg_addr]<=1 next edge. A set and clear of the same bit in one
//   cycle leaves it set. cfg_init sets the init flag.
//  Slot timing: a slot lasts CLK_DIV clk cycles. The divider counts 0..CLK_DIV-1 only while busy.
//   chip_clk=1 for counts HALF..CLK_DIV-1 (it rises mid-slot). Data/rst change only at slot boundaries, where
//   chip_clk falls, so the chip samples on the rising edge.
//  FSM: IDLE -> PRE -> FRAME -> IDLE.
//   IDLE: chip_clk=0. If en && (init || |dirty), go to PRE when init, else go to FRAME. Slot 0 is driven on the next edge.
//   PRE, 3 slots (rst,data): P0=(0,0) P1=(0,1) P2=(1,1). The init flag clears on entering PRE.
//   Leave PRE for FRAME if |dirty, else go to IDLE.
//   FRAME, 12 slots, rst=1: start bit 0, cfg addr[0..2] LSB-first, level[0..7] LSB-first.
//  Frame capture: on FRAME entry, the first dirty channel at or after the rr pointer (wrapping 7->0) is selected.
//   Its table value is latched into the shift register, dirty[ch] clears, cur_ch=ch, and the pointer becomes ch+1 mod 8.
//   A write to that channel during its frame does not alter the frame. It re-sets dirty, so the new value is sent later.
//  End of frame: if en && |dirty, the next frame starts in the very next slot with no gap. Otherwise go to IDLE.
//  Entering IDLE: busy=0, done=1 for one cycle, chip_rst=1, chip_data_in=1, chip_clk=0.
//  Dropping en mid-sequence: the current PRE/FRAME completes, then the FSM goes to IDLE. Remaining dirty bits are kept.
//  busy=1 from the first slot to the last slot inclusive. Preamble+one frame = 15*CLK_DIV cycles.
//  Divider counter width is $clog2(CLK_DIV). It resets to 0 on each IDLE exit.
// TESTING (bench CLK_DIV=8)
//  Reset, en=1, no writes -> preamble only. rst/data = (0,0),(0,1),(1,1), 8 cycles each, 3 chip_clk pulses.
//   Then done pulse, chip_rst=1, data=1.
//  After the init sequence, write ch5=0xA5 -> 12 slots (96 cycles).
//   Data 0, 1,0,1, 1,0,1,0,0,1,0,1; cur_ch=5; dirty=0 at end.
//  Write ch2 and ch6 with pointer=0 -> frames ch2 then ch6 back-to-back, no idle slot, single done pulse.
//  Rewrite ch2=0x3C mid-frame of ch2=0x11 -> 0x11 frame completes, then a 0x3C frame follows.
//  Assert rst mid-frame -> same cycle, chip_clk=0, chip_rst=0, data=0, busy=0. Next sequence starts with preamble.
//  ch1,ch4 dirty, en dropped during ch1 frame -> ch1 frame completes, IDLE, dirty=8'h10 held until en=1.

Source files
------------

// File: rtl/dac_update_scheduler.sv
// Serial DAC-programming link: holds an 8-entry level table, tracks changed channels and
// ships their 12-slot frames round-robin on a divided chip clock, preceded by a chip-reset preamble when requested.
module dac_update_scheduler #(
    parameter int CLK_DIV = 4000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       cfg_we,
    input  logic [2:0] cfg_addr,
    input  logic [7:0] cfg_level,
    input  logic       cfg_init,
    output logic       chip_clk,
    output logic       chip_rst,
    output logic       chip_data_in,
    output logic       busy,
    output logic       done,
    output logic [2:0] cur_ch,
    output logic [7:0] dirty
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST    = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF_M1 = CW'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {IDLE, PRE, FRAME} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      slot_q;
    logic [7:0]      table_q [8];
    logic [7:0]      dirty_q, dirty_d;
    logic            init_q;
    logic [2:0]      ptr_q;
    logic [2:0]      cur_ch_q;
    logic [11:0]     frame_q;
    logic            busy_q, done_q, chip_clk_q, chip_rst_q, chip_data_q;

    logic            sel_found;
    logic [2:0]      sel_ch, idx;
    logic            slot_last, seq_end, start, capture;

    // Round-robin pick: first dirty channel at or after the pointer, wrapping.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        sel_found = 1'b0;
        sel_ch    = ptr_q;
        idx       = '0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr_q + 3'(i);
            if (!sel_found && dirty_q[idx]) begin
                sel_found = 1'b1;
                sel_ch    = idx;
            end
        end
    end

    always_comb begin
        slot_last = (state_q == PRE) ? (slot_q == 4'd2) : (slot_q == 4'd11);
        seq_end   = busy_q && (cnt_q == CNT_LAST) && slot_last;
        start     = (state_q == IDLE) && en && (init_q || sel_found);
        capture   = (start && !init_q) || (seq_end && en && sel_found);
        // A host write in the capture cycle wins over the clear, so the newer value is resent.
        dirty_d = dirty_q;
        if (capture) dirty_d[sel_ch] = 1'b0;
        if (cfg_we)  dirty_d[cfg_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            slot_q      <= '0;
            // NOTE: the level table is small and must read as zero after reset, so it is reset like any register.
            for (int i = 0; i < 8; i++) table_q[i] <= '0;
            dirty_q     <= '0;
            init_q      <= 1'b1;
            ptr_q       <= '0;
            cur_ch_q    <= '0;
            frame_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            chip_clk_q  <= 1'b0;
            chip_rst_q  <= 1'b0;
            chip_data_q <= 1'b0;
        end else begin
            // NOTE: all state uses non-blocking assignments; later assignments in this block override earlier ones.
            done_q  <= 1'b0;
            dirty_q <= dirty_d;
            if (cfg_we) table_q[cfg_addr] <= cfg_level;

            if (capture) begin
                frame_q  <= {table_q[sel_ch], sel_ch, 1'b0};
                cur_ch_q <= sel_ch;
                ptr_q    <= sel_ch + 3'd1;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q      <= 1'b1;
                        cnt_q       <= '0;
                        slot_q      <= '0;
                        chip_clk_q  <= 1'b0;
                        chip_data_q <= 1'b0;
                        if (init_q) begin
                            state_q    <= PRE;
                            init_q     <= 1'b0;
                            chip_rst_q <= 1'b0;
                        end else begin
                            state_q    <= FRAME;
                            chip_rst_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (cnt_q != CNT_LAST) begin
                        cnt_q      <= cnt_q + 1'b1;
                        chip_clk_q <= (cnt_q >= CNT_HALF_M1);
                    end else begin
                        cnt_q      <= '0;
                        chip_clk_q <= 1'b0;
                        slot_q     <= slot_q + 4'd1;
                        if (!slot_last) begin
                            if (state_q == PRE) begin
                                chip_rst_q  <= (slot_q == 4'd1);
                                chip_data_q <= 1'b1;
                            end else begin
                                frame_q     <= frame_q >> 1;
                                chip_data_q <= frame_q[1];
                            end
                        end else if (en && sel_found) begin
                            state_q     <= FRAME;
                            slot_q      <= '0;
                            chip_rst_q  <= 1'b1;
                            chip_data_q <= 1'b0;
                        end else begin
                            state_q     <= IDLE;
                            slot_q      <= '0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            chip_rst_q  <= 1'b1;
                            chip_data_q <= 1'b1;
                        end
                    end
                end
            endcase

            if (cfg_init) init_q <= 1'b1;
        end
    end

    assign chip_clk     = chip_clk_q;
    assign chip_rst     = chip_rst_q;
    assign chip_data_in = chip_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cur_ch       = cur_ch_q;
    assign dirty        = dirty_q;

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Bench for dac_update_scheduler: slot-list reference model checked every cycle,
// plus literal expectations on the serial bits captured at each chip_clk rising edge.
module tb_dac_update_scheduler;

    localparam int CLK_DIV = 8;
    localparam int HALF    = CLK_DIV / 2;

    logic       clk = 1'b0;
    logic       rst, en, cfg_we, cfg_init;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_level;
    logic       chip_clk, chip_rst, chip_data_in, busy, done;
    logic [2:0] cur_ch;
    logic [7:0] dirty;

    int n_pass = 0;
    int n_total = 0;

    dac_update_scheduler #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_level(cfg_level), .cfg_init(cfg_init), .chip_clk(chip_clk),
        .chip_rst(chip_rst), .chip_data_in(chip_data_in), .busy(busy),
        .done(done), .cur_ch(cur_ch), .dirty(dirty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a sequence is a list of (rst,data) slots, each CLK_DIV cycles long.
    logic [7:0] m_table [8];
    logic [7:0] m_dirty;
    logic       m_init, m_busy, m_done;
    logic [2:0] m_ptr, m_cur;
    logic [1:0] m_idle;
    logic [1:0] m_slots [$];
    int         m_pos;

    task automatic model_frame();
        int c;
        logic [11:0] v;
        bit found = 0;
        for (int k = 0; k < 8; k++) begin
            c = (int'(m_ptr) + k) % 8;
            if (!found && m_dirty[c]) begin
                found = 1;
                v = {m_table[c], 3'(c), 1'b0};
                m_slots.delete();
                for (int i = 0; i < 12; i++) m_slots.push_back({1'b1, v[i]});
                m_dirty[c] = 1'b0;
                m_cur = 3'(c);
                m_ptr = 3'((c + 1) % 8);
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 0; m_done = 0; m_dirty = '0; m_init = 1; m_ptr = '0; m_cur = '0;
            m_pos = 0; m_idle = 2'b00; m_slots.delete();
            for (int i = 0; i < 8; i++) m_table[i] = '0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (en && (m_init || m_dirty != 0)) begin
                    m_busy = 1;
                    m_pos = 0;
                    if (m_init) begin
                        m_init = 0;
                        m_slots = '{2'b00, 2'b01, 2'b11};
                    end else model_frame();
                end
            end else begin
                m_pos++;
                if (m_pos == m_slots.size() * CLK_DIV) begin
                    if (en && m_dirty != 0) begin
                        model_frame();
                        m_pos = 0;
                    end else begin
                        m_busy = 0; m_done = 1; m_idle = 2'b11;
                    end
                end
            end
            if (cfg_we) begin
                m_table[cfg_addr] = cfg_level;
                m_dirty[cfg_addr] = 1'b1;
            end
            if (cfg_init) m_init = 1;
        end
    end

    function automatic logic [15:0] model_out();
        logic [1:0] s;
        logic       ck;
        s  = m_busy ? m_slots[m_pos / CLK_DIV] : m_idle;
        ck = m_busy && ((m_pos % CLK_DIV) >= HALF);
        return {ck, s, m_busy, m_done, m_cur, m_dirty};
    endfunction

    function automatic logic [15:0] dut_out();
        return {chip_clk, chip_rst, chip_data_in, busy, done, cur_ch, dirty};
    endfunction

    always @(posedge clk) begin
        #1;
        if (rst) check("cycle", 32'(dut_out()), 32'(model_out()));
    end

    // Observation: what the chip samples, plus busy/done activity per test.
    logic [1:0] cap [$];
    int busy_cnt, done_cnt;
    always @(posedge chip_clk) cap.push_back({chip_rst, chip_data_in});
    always @(posedge clk) begin
        #2;
        if (busy) busy_cnt++;
        if (done) done_cnt++;
    end

    function automatic logic [5:0] pre_pairs(input int first);
        logic [5:0] v = '0;
        for (int i = 0; i < 3; i++) v = {v[3:0], cap[first + i]};
        return v;
    endfunction

    function automatic logic [11:0] frame_bits(input int first);
        logic [11:0] v = '0;
        for (int i = 0; i < 12; i++) v[i] = cap[first + i][0];
        return v;
    endfunction

    task automatic start_test();
        @(negedge clk);
        cap.delete();
        busy_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic write_ch(input logic [2:0] ch, input logic [7:0] lvl);
        @(negedge clk);
        cfg_we = 1; cfg_addr = ch; cfg_level = lvl;
        @(negedge clk);
        cfg_we = 0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!(done_cnt > 0 && !busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_total++;
            $display("FAIL %s: timeout after %0d cycles, busy=%0b done_cnt=%0d", name, n, busy, done_cnt);
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int n;
        rst = 0; en = 0; cfg_we = 0; cfg_addr = '0; cfg_level = '0; cfg_init = 0;
        repeat (3) @(negedge clk);
        check("reset_state", 32'(dut_out()), 32'h0);
        rst = 1;

        // Preamble only after reset
        start_test();
        en = 1;
        wait_idle("pre_only", 400);
        check("pre_len", cap.size(), 3);
        check("pre_bits", 32'(pre_pairs(0)), 32'b000111);
        check("pre_busy", busy_cnt, 24);
        check("pre_done", done_cnt, 1);
        check("pre_idle_lines", {chip_rst, chip_data_in}, 2'b11);

        // Single frame ch5 = 0xA5
        start_test();
        write_ch(3'd5, 8'hA5);
        wait_idle("ch5", 400);
        check("ch5_len", cap.size(), 12);
        check("ch5_bits", 32'(frame_bits(0)), 32'hA5A);
        check("ch5_busy", busy_cnt, 96);
        check("ch5_cur", cur_ch, 3'd5);
        check("ch5_dirty", dirty, 8'h00);

        // Pointer back to 0: ch2 and ch6 back-to-back after the preamble
        @(negedge clk); rst = 0; en = 0;
        @(negedge clk); rst = 1;
        write_ch(3'd2, 8'h42);
        write_ch(3'd6, 8'h66);
        start_test();
        en = 1;
        wait_idle("two_frames", 600);
        check("two_len", cap.size(), 27);
        check("two_pre", 32'(pre_pairs(0)), 32'b000111);
        check("two_first", 32'(frame_bits(3)), 32'h424);
        check("two_second", 32'(frame_bits(15)), 32'h66C);
        check("two_busy", busy_cnt, 216);
        check("two_done", done_cnt, 1);
        check("two_cur", cur_ch, 3'd6);

        // Rewrite during own frame: old value completes, new value follows
        start_test();
        write_ch(3'd2, 8'h11);
        repeat (40) @(negedge clk);
        write_ch(3'd2, 8'h3C);
        wait_idle("rewrite", 600);
        check("rw_len", cap.size(), 24);
        check("rw_first", 32'(frame_bits(0)), 32'h114);
        check("rw_second", 32'(frame_bits(12)), 32'h3C4);
        check("rw_busy", busy_cnt, 192);
        check("rw_done", done_cnt, 1);

        // Async reset mid-frame while chip_clk and data are high
        start_test();
        write_ch(3'd3, 8'hFF);
        n = 0;
        while (!(chip_clk && chip_data_in && busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_total++;
            $display("FAIL rst_wait: timeout, chip_clk=%0b data=%0b", chip_clk, chip_data_in);
        end
        rst = 0;
        #1;
        check("rst_async", {chip_clk, chip_rst, chip_data_in, busy}, 4'b0000);
        @(negedge clk); rst = 1;
        check("rst_dirty", dirty, 8'h00);
        start_test();
        wait_idle("rst_pre", 400);
        check("rst_pre_len", cap.size(), 3);
        check("rst_pre_bits", 32'(pre_pairs(0)), 32'b000111);

        // en dropped during ch1 frame: ch4 stays pending
        en = 0;
        write_ch(3'd1, 8'h81);
        write_ch(3'd4, 8'h44);
        check("en_dirty_two", dirty, 8'h12);
        start_test();
        en = 1;
        repeat (20) @(negedge clk);
        en = 0;
        wait_idle("en_drop", 400);
        check("en_len", cap.size(), 12);
        check("en_bits", 32'(frame_bits(0)), 32'h812);
        check("en_busy", busy_cnt, 96);
        check("en_cur", cur_ch, 3'd1);
        check("en_dirty", dirty, 8'h10);
        repeat (30) @(negedge clk);
        check("en_hold_dirty", dirty, 8'h10);
        check("en_hold_busy", busy, 1'b0);
        start_test();
        en = 1;
        wait_idle("en_resume", 400);
        check("resume_bits", 32'(frame_bits(0)), 32'h448);
        check("resume_cur", cur_ch, 3'd4);
        check("resume_dirty", dirty, 8'h00);

        // cfg_init request: preamble then frame, 15 slots
        en = 0;
        @(negedge clk); cfg_init = 1;
        @(negedge clk); cfg_init = 0;
        write_ch(3'd0, 8'h5A);
        start_test();
        en = 1;
        wait_idle("init_req", 500);
        check("init_len", cap.size(), 15);
        check("init_pre", 32'(pre_pairs(0)), 32'b000111);
        check("init_frame", 32'(frame_bits(3)), 32'h5A0);
        check("init_busy", busy_cnt, 120);
        check("init_done", done_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
